// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//
// Bundle between the control/CSR side and the registered PC sequencer.
//
// Request side (driven by control/CSR, modport master):
//   pc_stall         hold request from the hazard unit
//   write_done       data-memory write complete (0 behaves like pc_stall=1)
//   trapped          trap entry request
//   trap_return      mret request
//   jump             JAL/JALR redirect request
//   branch_taken     conditional branch taken
//   inst_compressed  current instruction is 16-bit
//   jump_target      jump destination
//   imm              branch offset, two's complement
//   trap_target      mtvec-derived handler address
//   return_target    mepc
//
// Response side (driven by the sequencer, modport slave):
//   pc                current registered PC
//   next_pc           value pc takes at the next edge
//   redirect_pending  a buffered redirect waits for the stall to release
//   misaligned        one-cycle pulse for a dropped misaligned target
//   misaligned_addr   offending target, valid while misaligned=1
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            pc_stall;
    logic            write_done;
    logic            trapped;
    logic            trap_return;
    logic            jump;
    logic            branch_taken;
    logic            inst_compressed;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] return_target;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            redirect_pending;
    logic            misaligned;
    logic [XLEN-1:0] misaligned_addr;

    modport master (
        output pc_stall, write_done, trapped, trap_return, jump, branch_taken,
               inst_compressed, jump_target, imm, trap_target, return_target,
        input  pc, next_pc, redirect_pending, misaligned, misaligned_addr
    );

    modport slave (
        input  pc_stall, write_done, trapped, trap_return, jump, branch_taken,
               inst_compressed, jump_target, imm, trap_target, return_target,
        output pc, next_pc, redirect_pending, misaligned, misaligned_addr
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Registered program-counter unit for the RV32 core. Picks the next PC by
// priority (trap > mret > jump > taken branch > sequential), holds the PC
// during stalls and keeps one buffered redirect so a redirect raised while
// stalled is applied when the stall releases instead of being lost.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset (wins over every other input)
//   bus    pc_sequencer_if.slave: request inputs and PC outputs
//
// Parameters:
//   XLEN          PC / address width (must match the interface instance)
//   RESET_VECTOR  PC loaded by reset
//   COMPRESSED    1: +2 stepping allowed, alignment checked on bit [0]
//                 0: always +4, alignment checked on bits [1:0]
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              COMPRESSED   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_sequencer_if.slave        bus
);

    // Priority class of a redirect. Jump and branch share a class: they are
    // mutually exclusive in a real instruction stream.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_JB     = 2'd1,
        CLS_MRET   = 2'd2,
        CLS_TRAP   = 2'd3
    } req_class_e;

    localparam logic [1:0] ALIGN_MASK = COMPRESSED ? 2'b01 : 2'b11;

    // Architectural state
    logic [XLEN-1:0] pc_q;
    logic            pend_valid_q;
    req_class_e      pend_cls_q;
    logic [XLEN-1:0] pend_target_q;
    logic            mis_q;
    logic [XLEN-1:0] mis_addr_q;

    // Next-state values
    logic [XLEN-1:0] pc_d;
    logic            pend_valid_d;
    req_class_e      pend_cls_d;
    logic [XLEN-1:0] pend_target_d;
    logic            mis_d;
    logic [XLEN-1:0] mis_addr_d;

    // Request decode
    logic            stall;
    logic [XLEN-1:0] seq_pc;
    req_class_e      req_cls;
    logic [XLEN-1:0] req_target;
    logic            req_bad;
    logic            req_beats_pend;

    assign stall  = bus.pc_stall | ~bus.write_done;
    assign seq_pc = pc_q + ((COMPRESSED && bus.inst_compressed) ? XLEN'(2) : XLEN'(4));

    // Winning request. With no redirect the target falls back to the
    // sequential PC, so the unstalled path below needs no extra case.
    always_comb begin : request_select
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        req_cls    = CLS_NONE;
        req_target = seq_pc;
        if (bus.trapped) begin
            req_cls    = CLS_TRAP;
            req_target = bus.trap_target & ~XLEN'(3);
        end else if (bus.trap_return) begin
            req_cls    = CLS_MRET;
            req_target = bus.return_target;
        end else if (bus.jump) begin
            req_cls    = CLS_JB;
            req_target = bus.jump_target;
        end else if (bus.branch_taken) begin
            req_cls    = CLS_JB;
            req_target = pc_q + bus.imm;
        end
    end

    // Trap targets are forced aligned and never flagged.
    assign req_bad = ((req_cls == CLS_MRET) || (req_cls == CLS_JB))
                     && (|(req_target[1:0] & ALIGN_MASK));

    // A fresh request overrides a buffered one only at equal or higher class.
    assign req_beats_pend = (req_cls != CLS_NONE)
                            && (!pend_valid_q || (req_cls >= pend_cls_q));

    always_comb begin : next_state
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_cls_d    = pend_cls_q;
        pend_target_d = pend_target_q;
        mis_d         = 1'b0;
        mis_addr_d    = mis_addr_q;

        if (req_bad) begin
            // Dropped outright: pc and buffer untouched, the trap unit is
            // expected to follow up with a trap request.
            mis_d      = 1'b1;
            mis_addr_d = req_target;
        end else if (stall) begin
            if (req_beats_pend) begin
                pend_valid_d  = 1'b1;
                pend_cls_d    = req_cls;
                pend_target_d = req_target;
            end
        end else begin
            pend_valid_d = 1'b0;
            if (pend_valid_q && !req_beats_pend) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = req_target;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_cls_q    <= CLS_NONE;
            pend_target_q <= '0;
            mis_q         <= 1'b0;
            mis_addr_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_cls_q    <= pend_cls_d;
            pend_target_q <= pend_target_d;
            mis_q         <= mis_d;
            mis_addr_q    <= mis_addr_d;
        end
    end

    assign bus.pc               = pc_q;
    // Reset is folded in so next_pc is exact on the reset edge too.
    assign bus.next_pc          = reset ? RESET_VECTOR : pc_d;
    assign bus.redirect_pending = pend_valid_q;
    assign bus.misaligned       = mis_q;
    assign bus.misaligned_addr  = mis_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Two instances share one stimulus: dut0 (COMPRESSED=0) and dut1
// (COMPRESSED=1), both with RESET_VECTOR=32'h1000. Directed steps check
// fixed values; a random phase compares both against a queue-based model.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_1000;

    typedef struct packed {
        logic        reset;
        logic        pc_stall;
        logic        write_done;
        logic        trapped;
        logic        trap_return;
        logic        jump;
        logic        branch_taken;
        logic        inst_compressed;
        logic [31:0] jump_target;
        logic [31:0] imm;
        logic [31:0] trap_target;
        logic [31:0] return_target;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pv;
        logic [1:0]  pcls;
        logic [31:0] ptgt;
        logic        mis;
        logic [31:0] maddr;
    } model_t;

    typedef struct packed {
        logic [1:0]  cls;
        logic [31:0] tgt;
        logic        chk;
    } req_t;

    logic   clk = 1'b0;
    logic   reset;
    stim_t  s;
    model_t m0, m1;
    int     n_cmp  = 0;
    int     n_fail = 0;

    pc_sequencer_if #(.XLEN(32)) bus0 ();
    pc_sequencer_if #(.XLEN(32)) bus1 ();

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .COMPRESSED(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .COMPRESSED(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Reference: list the asserted requests in priority order, the head wins.
    function automatic model_t model_next(model_t m, stim_t st, bit comp);
        req_t   q[$];
        model_t n = m;
        logic   stall;
        int     step;
        if (st.reset) begin
            n = '0;
            n.pc = RV;
            return n;
        end
        if (st.trapped)      q.push_back('{cls: 2'd3, tgt: st.trap_target & 32'hFFFF_FFFC, chk: 1'b0});
        if (st.trap_return)  q.push_back('{cls: 2'd2, tgt: st.return_target, chk: 1'b1});
        if (st.jump)         q.push_back('{cls: 2'd1, tgt: st.jump_target, chk: 1'b1});
        if (st.branch_taken) q.push_back('{cls: 2'd1, tgt: m.pc + st.imm, chk: 1'b1});
        stall = st.pc_stall || !st.write_done;
        step  = (comp && st.inst_compressed) ? 2 : 4;
        n.mis = 1'b0;
        if (q.size() > 0 && q[0].chk && (q[0].tgt % 32'(comp ? 2 : 4)) != 0) begin
            n.mis   = 1'b1;
            n.maddr = q[0].tgt;
            return n;
        end
        if (stall) begin
            if (q.size() > 0 && (!m.pv || q[0].cls >= m.pcls)) begin
                n.pv   = 1'b1;
                n.pcls = q[0].cls;
                n.ptgt = q[0].tgt;
            end
        end else begin
            n.pv = 1'b0;
            if (q.size() > 0 && (!m.pv || q[0].cls >= m.pcls)) n.pc = q[0].tgt;
            else if (m.pv)                                     n.pc = m.ptgt;
            else                                               n.pc = m.pc + 32'(step);
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        reset                = s.reset;
        bus0.pc_stall        = s.pc_stall;        bus1.pc_stall        = s.pc_stall;
        bus0.write_done      = s.write_done;      bus1.write_done      = s.write_done;
        bus0.trapped         = s.trapped;         bus1.trapped         = s.trapped;
        bus0.trap_return     = s.trap_return;     bus1.trap_return     = s.trap_return;
        bus0.jump            = s.jump;            bus1.jump            = s.jump;
        bus0.branch_taken    = s.branch_taken;    bus1.branch_taken    = s.branch_taken;
        bus0.inst_compressed = s.inst_compressed; bus1.inst_compressed = s.inst_compressed;
        bus0.jump_target     = s.jump_target;     bus1.jump_target     = s.jump_target;
        bus0.imm             = s.imm;             bus1.imm             = s.imm;
        bus0.trap_target     = s.trap_target;     bus1.trap_target     = s.trap_target;
        bus0.return_target   = s.return_target;   bus1.return_target   = s.return_target;
    endtask

    // Drive, advance the models on the same inputs, clock, sample 1 after.
    task automatic tick();
        drive();
        m0 = model_next(m0, s, 1'b0);
        m1 = model_next(m1, s, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        s.jump        = 1'b1;
        s.jump_target = addr;
        tick();
        s.jump        = 1'b0;
    endtask

    task automatic stall_jump_seq(input string tag, input bit use_wd);
        go_to(32'h100);
        if (use_wd) s.write_done = 1'b0; else s.pc_stall = 1'b1;
        s.jump = 1'b1; s.jump_target = 32'h200;
        tick();
        check({tag, "_pc1"}, bus0.pc, 32'h100);
        check({tag, "_pend1"}, 32'(bus0.redirect_pending), 32'd1);
        s.jump = 1'b0;
        tick();
        check({tag, "_pc2"}, bus0.pc, 32'h100);
        check({tag, "_next2"}, bus0.next_pc, 32'h100);
        tick();
        check({tag, "_pend3"}, 32'(bus0.redirect_pending), 32'd1);
        s.pc_stall = 1'b0; s.write_done = 1'b1;
        drive(); #1;
        check({tag, "_next_rel"}, bus0.next_pc, 32'h200);
        tick();
        check({tag, "_pc_rel"}, bus0.pc, 32'h200);
        check({tag, "_pend_rel"}, 32'(bus0.redirect_pending), 32'd0);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t = $urandom;
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    function automatic stim_t rand_stim();
        stim_t       r;
        logic [31:0] b = $urandom;
        r.reset           = ($urandom_range(0, 99) == 0);
        r.pc_stall        = ($urandom_range(0, 99) < 30);
        r.write_done      = ($urandom_range(0, 99) >= 15);
        r.trapped         = ($urandom_range(0, 99) < 8);
        r.trap_return     = ($urandom_range(0, 99) < 8);
        r.jump            = ($urandom_range(0, 99) < 15);
        r.branch_taken    = ($urandom_range(0, 99) < 15);
        r.inst_compressed = 1'($urandom_range(0, 1));
        r.jump_target     = rand_target();
        r.trap_target     = $urandom;
        r.return_target   = rand_target();
        r.imm             = {{20{b[11]}}, b[11:0]};
        if ($urandom_range(0, 9) != 0) r.imm[1:0] = 2'b00;
        return r;
    endfunction

    initial begin
        model_t p0, p1;
        s = '0;
        s.write_done = 1'b1;
        s.reset      = 1'b1;

        // Reset and sequential stepping
        tick();
        check("rst_pc", bus0.pc, RV);
        check("rst_pend", 32'(bus0.redirect_pending), 32'd0);
        check("rst_mis", 32'(bus0.misaligned), 32'd0);
        check("rst_maddr", bus0.misaligned_addr, 32'h0);
        check("rst_pc_c", bus1.pc, RV);
        s.reset = 1'b0;
        tick();
        check("seq1", bus0.pc, 32'h1004);
        tick();
        check("seq2", bus0.pc, 32'h1008);

        // Priority
        go_to(32'h0);
        s.trapped = 1'b1; s.jump = 1'b1; s.branch_taken = 1'b1;
        s.trap_target = 32'h33; s.jump_target = 32'h10; s.imm = 32'h20;
        tick();
        check("prio_trap", bus0.pc, 32'h30);
        s.trapped = 1'b0; s.branch_taken = 1'b0;
        go_to(32'h0);
        go_to(32'h10);
        check("prio_jump", bus0.pc, 32'h10);
        go_to(32'h0);
        s.branch_taken = 1'b1; s.imm = 32'h20;
        drive(); #1;
        check("prio_br_next", bus0.next_pc, 32'h20);
        tick();
        check("prio_branch", bus0.pc, 32'h20);
        s.branch_taken = 1'b0;

        // Stall buffering via each stall source
        stall_jump_seq("stall", 1'b0);
        stall_jump_seq("wdone", 1'b1);

        // Pending override, both orders
        go_to(32'h100);
        s.pc_stall = 1'b1; s.jump = 1'b1; s.jump_target = 32'h200;
        tick();
        s.jump = 1'b0; s.trapped = 1'b1; s.trap_target = 32'h80;
        tick();
        s.trapped = 1'b0; s.pc_stall = 1'b0;
        tick();
        check("ovr_jt", bus0.pc, 32'h80);
        go_to(32'h100);
        s.pc_stall = 1'b1; s.trapped = 1'b1;
        tick();
        s.trapped = 1'b0; s.jump = 1'b1; s.jump_target = 32'h200;
        tick();
        s.jump = 1'b0; s.pc_stall = 1'b0;
        tick();
        check("ovr_tj", bus0.pc, 32'h80);
        check("ovr_tj_pend", 32'(bus0.redirect_pending), 32'd0);

        // Compressed stepping and misalignment
        go_to(32'h40);
        s.inst_compressed = 1'b1;
        tick();
        check("cstep_c0", bus0.pc, 32'h44);
        check("cstep_c1", bus1.pc, 32'h42);
        s.jump = 1'b1; s.jump_target = 32'h102;
        tick();
        check("mis_pc", bus0.pc, 32'h44);
        check("mis_flag", 32'(bus0.misaligned), 32'd1);
        check("mis_addr", bus0.misaligned_addr, 32'h102);
        check("mis_c1_pc", bus1.pc, 32'h102);
        check("mis_c1_flag", 32'(bus1.misaligned), 32'd0);
        s.jump = 1'b0; s.inst_compressed = 1'b0;
        tick();
        check("mis_pulse", 32'(bus0.misaligned), 32'd0);
        check("mis_after", bus0.pc, 32'h48);

        // Wrap, then reset in the middle of a stall
        go_to(32'hFFFF_FFFC);
        tick();
        check("wrap", bus0.pc, 32'h0);
        s.pc_stall = 1'b1; s.jump = 1'b1; s.jump_target = 32'h200;
        tick();
        check("rstst_pend", 32'(bus0.redirect_pending), 32'd1);
        s.jump = 1'b0; s.reset = 1'b1;
        tick();
        check("rstst_pc", bus0.pc, RV);
        check("rstst_pend0", 32'(bus0.redirect_pending), 32'd0);
        s.reset = 1'b0; s.pc_stall = 1'b0;
        tick();
        check("rstst_after", bus0.pc, 32'h1004);

        // Random phase against the model
        s = '0; s.write_done = 1'b1; s.reset = 1'b1;
        tick();
        for (int i = 0; i < 2000; i++) begin
            s = rand_stim();
            drive(); #1;
            p0 = model_next(m0, s, 1'b0);
            p1 = model_next(m1, s, 1'b1);
            check("rnd_next0", bus0.next_pc, p0.pc);
            check("rnd_next1", bus1.next_pc, p1.pc);
            tick();
            check("rnd_pc0", bus0.pc, m0.pc);
            check("rnd_pc1", bus1.pc, m1.pc);
            check("rnd_pend0", 32'(bus0.redirect_pending), 32'(m0.pv));
            check("rnd_pend1", 32'(bus1.redirect_pending), 32'(m1.pv));
            check("rnd_mis0", 32'(bus0.misaligned), 32'(m0.mis));
            check("rnd_mis1", 32'(bus1.misaligned), 32'(m1.mis));
            if (m0.mis) check("rnd_maddr0", bus0.misaligned_addr, m0.maddr);
            if (m1.mis) check("rnd_maddr1", bus1.misaligned_addr, m1.maddr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the RV32 core that owns the PC state rather than computing next-PC combinationally.
- Selects the next PC by priority among trap entry, trap return (mret), jump, taken branch and sequential increment.
- Holds the PC while the pipeline is stalled, and buffers any redirect that arrives during a stall so it is applied later instead of lost.
- Sits between the control/CSR units and instruction fetch. Adds parametrised width, reset vector, optional compressed (+2) stepping and target-misalignment detection.

Parameters:
- XLEN, 32, width of the PC and of all address inputs.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- COMPRESSED, 0. When 1, the sequential step may be 2 and the alignment check is on bit [0]. When 0, the step is always 4 and the alignment check is on bits [1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_stall  in  1  hold request from the hazard unit.
- write_done  in  1  data-memory write complete; 0 stalls exactly as pc_stall=1 does.
- trapped  in  1  trap entry request.
- trap_return  in  1  mret request.
- jump  in  1  JAL/JALR redirect request.
- branch_taken  in  1  conditional branch taken.
- inst_compressed  in  1  current instruction is 16-bit; ignored when COMPRESSED=0.
- jump_target  in  XLEN  jump destination.
- imm  in  XLEN  branch offset, two's complement.
- trap_target  in  XLEN  mtvec-derived handler address.
- return_target  in  XLEN  mepc.
- pc  out  XLEN  current PC (registered).
- next_pc  out  XLEN  value pc will take at the next edge (combinational).
- redirect_pending  out  1  a buffered redirect is waiting for the stall to release.
- misaligned  out  1  one-cycle pulse: a jump/branch/mret target was misaligned.
- misaligned_addr  out  XLEN  the offending target, valid while misaligned=1.

Behaviour:
- Reset (synchronous, takes priority over every other input):
  - pc = RESET_VECTOR.
  - pending register cleared; redirect_pending = 0.
  - misaligned = 0; misaligned_addr = 0.
  - Reset asserted mid-stall discards any pending redirect.
- Stall condition: stall = pc_stall | ~write_done.
- Request priority, highest first: trapped > trap_return > jump > branch_taken > sequential.
- Requested target for each source:
  - trapped: trap_target with bits [1:0] forced to 0.
  - trap_return: return_target.
  - jump: jump_target.
  - branch_taken: pc + imm, computed modulo 2^XLEN.
  - sequential: pc + 2 when COMPRESSED=1 and inst_compressed=1; otherwise pc + 4. Wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0).
- Alignment check: applies to the jump, branch and mret targets; the trap target is never checked.
  - COMPRESSED=0: target is misaligned if target[1:0] != 0.
  - COMPRESSED=1: target is misaligned if target[0] != 0.
  - On a misaligned target: the redirect is dropped, pc holds, and misaligned=1 with misaligned_addr=target for the following cycle. The request is not buffered. The trap unit is expected to assert trapped next.
- Pending buffer: a single entry holding a target and a 2-bit priority class (3=trap, 2=mret, 1=jump/branch).
  - Not stalled, nothing pending: pc <= winning target.
  - Stalled: pc holds. An aligned redirect is written into the buffer if the buffer is empty or the new class >= the stored class. A lower-class request is discarded. Sequential requests are never buffered.
  - First unstalled cycle with an entry pending: if a new request of class >= the stored class is present, it wins; otherwise the pending target is loaded. The buffer clears on that edge.
  - redirect_pending mirrors the buffer's valid bit.
- next_pc equals the value pc will load at the next edge under the rules above. It equals pc while stalled.
- No combinational path from any input to pc.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_1000 -> pc=32'h0000_1000 at the first edge after reset. Release reset with all requests low -> pc=32'h0000_1004, then 32'h0000_1008.
- Priority: pc=0, trapped=1, jump=1, branch_taken=1, trap_target=32'h0000_0033 -> pc=32'h0000_0030. Repeat with jump only, jump_target=32'h10 -> pc=32'h10. Repeat with branch only, imm=32'h20 -> pc=32'h20.
- Stall buffering: pc=32'h100, pc_stall=1 for 3 cycles, jump=1 with jump_target=32'h200 in the first cycle only:
  - pc stays 32'h100; redirect_pending=1 for the stall cycles.
  - Stall released -> pc=32'h200 and redirect_pending=0.
  - Same sequence with write_done=0 instead of pc_stall=1 -> identical result.
- Pending override: during a stall, jump to 32'h200, then trapped with trap_target=32'h80 -> pc=32'h80 after release. Reverse order (trap first, then jump) -> pc=32'h80.
- Misalignment: COMPRESSED=0, jump_target=32'h102 -> pc held, misaligned=1 for one cycle, misaligned_addr=32'h102. COMPRESSED=1, inst_compressed=1, pc=32'h40 -> pc=32'h42, and jump_target=32'h102 is accepted.
- Wrap and reset mid-stall: pc=32'hFFFF_FFFC, no requests -> pc=0. Stall with a pending jump, then reset asserted -> pc=RESET_VECTOR and redirect_pending=0.
